// File: rtl/bus_arbiter.sv
// bus_arbiter: shares one AXI-lite-style slave between the IFU (read) and LSU (read/write).
// Define ARB_RR_EN for round-robin IFU/LSU arbitration; default is fixed LSU-first priority.
module bus_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [ADDR_W-1:0]   ifu_araddr,
  input  logic                ifu_arvalid,
  output logic [DATA_W-1:0]   ifu_rdata,
  output logic                ifu_rvalid,
  input  logic [ADDR_W-1:0]   lsu_araddr,
  input  logic                lsu_arvalid,
  output logic [DATA_W-1:0]   lsu_rdata,
  output logic                lsu_rvalid,
  input  logic [ADDR_W-1:0]   lsu_awaddr,
  input  logic                lsu_awvalid,
  input  logic [DATA_W-1:0]   lsu_wdata,
  input  logic [DATA_W/8-1:0] lsu_wstrb,
  output logic                lsu_bvalid,
  output logic [ADDR_W-1:0]   mem_araddr,
  output logic                mem_arvalid,
  input  logic                mem_arready,
  input  logic [DATA_W-1:0]   mem_rdata,
  input  logic                mem_rvalid,
  output logic                mem_rready,
  output logic [ADDR_W-1:0]   mem_awaddr,
  output logic                mem_awvalid,
  input  logic                mem_awready,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic [DATA_W/8-1:0] mem_wstrb,
  output logic                mem_wvalid,
  input  logic                mem_wready,
  input  logic                mem_bvalid,
  output logic                mem_bready,
  output logic [1:0]          arb_owner
);

  typedef enum logic [2:0] {
    IDLE,
    IFU_AR,
    IFU_R,
    LSU_AR,
    LSU_R,
    LSU_W,
    LSU_B
  } state_t;

  state_t state;
  state_t state_next;
  state_t grant_state;
  logic   aw_done;
  logic   aw_done_next;
  logic   w_done;
  logic   w_done_next;
  logic   lsu_req;
  state_t lsu_pick;

  // Write address/data and read data pass straight through; only the valids are sequenced
  assign mem_awaddr = lsu_awaddr;
  assign mem_wdata  = lsu_wdata;
  assign mem_wstrb  = lsu_wstrb;
  assign ifu_rdata  = mem_rdata;
  assign lsu_rdata  = mem_rdata;

  assign lsu_req  = lsu_awvalid | lsu_arvalid;
  assign lsu_pick = lsu_awvalid ? LSU_W : LSU_AR;

`ifdef ARB_RR_EN
  localparam logic OWNER_IFU = 1'b0;
  localparam logic OWNER_LSU = 1'b1;

  // last_owner remembers who won the most recent grant so the other side wins a tie
  logic last_owner;

  always_ff @(posedge clk) begin
    if (rst) begin
      last_owner <= OWNER_IFU;
    end else if (state == IDLE && state_next != IDLE) begin
      last_owner <= (state_next == IFU_AR) ? OWNER_IFU : OWNER_LSU;
    end
  end

  always_comb begin
    grant_state = IDLE;
    if (lsu_req && ifu_arvalid) begin
      grant_state = (last_owner == OWNER_LSU) ? IFU_AR : lsu_pick;
    end else if (lsu_req) begin
      grant_state = lsu_pick;
    end else if (ifu_arvalid) begin
      grant_state = IFU_AR;
    end
  end
`else
  always_comb begin
    grant_state = IDLE;
    if (lsu_req) begin
      grant_state = lsu_pick;
    end else if (ifu_arvalid) begin
      grant_state = IFU_AR;
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      aw_done <= 1'b0;
      w_done  <= 1'b0;
    end else begin
      state   <= state_next;
      aw_done <= aw_done_next;
      w_done  <= w_done_next;
    end
  end

  // Next-state and handshake outputs; responses outside R/B states are never accepted
  always_comb begin
    state_next   = state;
    aw_done_next = aw_done;
    w_done_next  = w_done;
    arb_owner    = 2'd0;
    mem_araddr   = lsu_araddr;
    mem_arvalid  = 1'b0;
    mem_rready   = 1'b0;
    mem_awvalid  = 1'b0;
    mem_wvalid   = 1'b0;
    mem_bready   = 1'b0;
    ifu_rvalid   = 1'b0;
    lsu_rvalid   = 1'b0;
    lsu_bvalid   = 1'b0;
    case (state)
      IDLE: begin
        state_next = grant_state;
      end
      IFU_AR: begin
        arb_owner   = 2'd1;
        mem_arvalid = 1'b1;
        mem_araddr  = ifu_araddr;
        if (mem_arready) state_next = IFU_R;
      end
      IFU_R: begin
        arb_owner  = 2'd1;
        mem_rready = 1'b1;
        if (mem_rvalid) begin
          ifu_rvalid = 1'b1;
          state_next = IDLE;
        end
      end
      LSU_AR: begin
        arb_owner   = 2'd2;
        mem_arvalid = 1'b1;
        mem_araddr  = lsu_araddr;
        if (mem_arready) state_next = LSU_R;
      end
      LSU_R: begin
        arb_owner  = 2'd2;
        mem_rready = 1'b1;
        if (mem_rvalid) begin
          lsu_rvalid = 1'b1;
          state_next = IDLE;
        end
      end
      LSU_W: begin
        arb_owner   = 2'd2;
        mem_awvalid = !aw_done;
        mem_wvalid  = !w_done;
        if ((aw_done || mem_awready) && (w_done || mem_wready)) begin
          aw_done_next = 1'b0;
          w_done_next  = 1'b0;
          state_next   = LSU_B;
        end else begin
          aw_done_next = aw_done || mem_awready;
          w_done_next  = w_done || mem_wready;
        end
      end
      LSU_B: begin
        arb_owner  = 2'd2;
        mem_bready = 1'b1;
        if (mem_bvalid) begin
          lsu_bvalid = 1'b1;
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

endmodule

// File: doc/bus_arbiter.md
Name: bus_arbiter

Overview:
- Two-master to one-slave arbiter for the core's single memory port: the fetch unit (IFU, read-only) and the load/store unit (LSU, read+write) share one AXI-lite-style downstream interface.
- Sits between the pipeline front-/back-end bus ports and the memory/crossbar.
- One outstanding transaction total. A registered state machine sequences address, data and response phases for the current owner.

Parameters:
- ADDR_W, 32, address width
- DATA_W, 32, data width

Ports:
clk  in  1  clock
rst  in  1  reset: synchronous, active-high
ifu_araddr  in  ADDR_W  IFU read address
ifu_arvalid  in  1  IFU read request; held with stable address until ifu_rvalid
ifu_rdata  out  DATA_W  IFU read data, valid when ifu_rvalid
ifu_rvalid  out  1  one-cycle IFU read completion pulse
lsu_araddr  in  ADDR_W  LSU read address
lsu_arvalid  in  1  LSU read request; held until lsu_rvalid
lsu_rdata  out  DATA_W  LSU read data
lsu_rvalid  out  1  one-cycle LSU read completion pulse
lsu_awaddr  in  ADDR_W  LSU write address
lsu_awvalid  in  1  LSU write request; held with stable awaddr/wdata/wstrb until lsu_bvalid
lsu_wdata  in  DATA_W  write data
lsu_wstrb  in  DATA_W/8  byte strobes
lsu_bvalid  out  1  one-cycle write completion pulse
mem_araddr  out  ADDR_W  downstream read address
mem_arvalid  out  1  downstream AR valid
mem_arready  in  1  downstream AR ready
mem_rdata  in  DATA_W  downstream read data
mem_rvalid  in  1  downstream R valid
mem_rready  out  1  downstream R ready
mem_awaddr  out  ADDR_W  downstream write address
mem_awvalid  out  1  downstream AW valid
mem_awready  in  1  downstream AW ready
mem_wdata  out  DATA_W  downstream write data
mem_wstrb  out  DATA_W/8  downstream strobes
mem_wvalid  out  1  downstream W valid
mem_wready  in  1  downstream W ready
mem_bvalid  in  1  downstream B valid
mem_bready  out  1  downstream B ready
arb_owner  out  2  current owner: 0 none, 1 IFU, 2 LSU (perf/debug)

Behaviour:
- States:
  - IDLE
  - IFU_AR, IFU_R
  - LSU_AR, LSU_R
  - LSU_W
  - LSU_B
- Reset:
  - state=IDLE, arb_owner=0.
  - aw_done=w_done=0.
  - All valid/ready outputs 0.
  - mem_* data/address outputs are don't-care while their valid is low.
- IDLE grant, sampled at the clock edge:
  - Priority: LSU write > LSU read > IFU read.
  - Next state is LSU_W, LSU_AR or IFU_AR respectively. No request: stay in IDLE.
- x_AR:
  - mem_arvalid=1, mem_araddr=owner address (combinational from the owner's input).
  - On mem_arready: go to x_R.
- x_R:
  - mem_rready=1.
  - On mem_rvalid, same cycle: owner rvalid=1 and owner rdata=mem_rdata. Next state IDLE.
- LSU_W:
  - mem_awvalid=!aw_done and mem_wvalid=!w_done.
  - Each flag sets on its handshake; AW and W may complete in either order or in the same cycle.
  - When both are complete (flag set or handshake this cycle), clear the flags and go to LSU_B.
- LSU_B:
  - mem_bready=1.
  - On mem_bvalid: lsu_bvalid=1 that cycle; next state IDLE.
- arb_owner is 1 in IFU states, 2 in LSU states, 0 in IDLE.
- Latency:
  - Minimum read is 3 cycles from request to rvalid (IDLE grant, AR accepted first cycle, R in the following cycle).
  - Minimum write is 3 cycles.
  - A mandatory IDLE cycle separates transactions. Masters must drop their valid the cycle after their completion pulse, so no stale regrant occurs.
- A non-owner request is stalled with no response and stays pending.
- A request withdrawn after grant is illegal; the arbiter still completes the downstream transaction.
- Reset mid-transaction:
  - Return to IDLE immediately and abandon the downstream transfer.
  - The slave shares rst.
- Downstream responses arriving outside R/B states are ignored (mem_rready/mem_bready low).

Optional Feature:
- Macro ARB_RR_EN.
- Defined:
  - IDLE arbitration between the IFU read and any LSU request is round-robin via a 1-bit last_owner register (reset = IFU).
  - The master that did not win last gets priority on conflict.
  - LSU write still beats LSU read within LSU.
- Undefined: fixed priority as above, and no last_owner register.

Test Plan:
- IFU read 0x80000000, slave arready immediate, rdata 0x00000413 one cycle later -> ifu_rvalid pulse with 0x00000413 exactly 3 cycles after request; arb_owner 1 then 0.
- IFU and LSU read request in the same cycle, fixed priority -> LSU read served first (mem_araddr=LSU addr); IFU served after an IDLE cycle. With ARB_RR_EN and last_owner=LSU -> IFU served first.
- LSU write 0x80001000 data 0xDEADBEEF wstrb 0xF, slave gives wready 2 cycles before awready -> each valid drops after its handshake; bready asserted; lsu_bvalid a single pulse.
- Slave holds arready low 5 cycles -> mem_arvalid and mem_araddr stable throughout; no master rvalid early.
- rst asserted while in IFU_R -> next cycle state IDLE, all mem valids/readies 0, no ifu_rvalid, arb_owner 0.
- Spurious mem_rvalid while in IDLE -> no ifu_rvalid/lsu_rvalid pulse.
